// File: rtl/toaplan2_gcu_pkg.sv
// Shared definitions for the Toaplan2 GCU command sequencer:
// GP9001 operation codes, dispatcher state encoding and the
// CPU address-to-operation decode.
package toaplan2_gcu_pkg;

   localparam logic [2:0] OP_SET_PTR = 3'd0;
   localparam logic [2:0] OP_WR_RAM  = 3'd1;
   localparam logic [2:0] OP_RD_H    = 3'd2;
   localparam logic [2:0] OP_RD_L    = 3'd3;
   localparam logic [2:0] OP_SEL_REG = 3'd4;
   localparam logic [2:0] OP_WR_REG  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] code;
   } op_dec_t;

   // addr is A[3:1]; hit=0 marks an unmapped address/direction pair
   function automatic op_dec_t decode_op(input logic rw, input logic [2:0] addr);
      op_dec_t d;
      d.hit  = 1'b1;
      d.code = OP_SET_PTR;
      if (!rw) begin
         case (addr)
            3'd0:       d.code = OP_SET_PTR;
            3'd2, 3'd3: d.code = OP_WR_RAM;
            3'd4:       d.code = OP_SEL_REG;
            3'd6:       d.code = OP_WR_REG;
            default:    d.hit  = 1'b0;
         endcase
      end else begin
         case (addr)
            3'd2:    d.code = OP_RD_H;
            3'd3:    d.code = OP_RD_L;
            default: d.hit  = 1'b0;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/toaplan2_gcu_seq_if.sv
// Request/acknowledge link between the sequencer (master) and the
// GP9001 command port (slave).
interface toaplan2_gcu_seq_if #(parameter int DW = 16);
   logic          op_valid;
   logic [2:0]    op_code;
   logic [DW-1:0] op_data;
   logic          gcu_ack;
   logic [DW-1:0] gcu_dout;

   modport master (output op_valid, op_code, op_data, input gcu_ack, gcu_dout);
   modport slave  (input op_valid, op_code, op_data, output gcu_ack, gcu_dout);
endinterface

// File: rtl/toaplan2_gcu_fifo.sv
// Posted-write FIFO: 2^AW entries of W bits, head visible on dout.
// Occupancy kept in an AW+1 bit count; pointers wrap modulo 2^AW.
module toaplan2_gcu_fifo #(
   parameter int W  = 19,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot, so push into full is legal then
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/toaplan2_gcu_seq.sv
// Toaplan2 GCU sequencer: turns 68k accesses in the GCU window into
// single GP9001 operations. Writes are posted through a small FIFO,
// reads wait for the FIFO to drain and for GCU data. Drives the busy
// term used by the DTACK generator.
// Optional build macro TOAPLAN2_GCU_TIMEOUT_EN adds a handshake
// watchdog with a sticky tmo_flag; without it tmo_flag is tied to 0.
module toaplan2_gcu_seq
   import toaplan2_gcu_pkg::*;
#(
   parameter int FIFO_AW = 2,
   parameter int DW      = 16,
   parameter int TMO_W   = 10
) (
   input  logic                CLK96,
   input  logic                RESET96,
   input  logic                cpu_cs,
   input  logic                cpu_rw,
   input  logic [2:0]          cpu_addr,
   input  logic [DW-1:0]       cpu_din,
   output logic                cpu_busy,
   output logic [DW-1:0]       cpu_dout,
   output logic                tmo_flag,
   toaplan2_gcu_seq_if.master  gcu
);

   localparam int FW = 3 + DW;

   op_dec_t       dec;
   state_t        state, state_nxt;
   logic          cs_d, done, start_wait, orphan;
   logic          wr_hold, read_pend, cur_is_read;
   logic [2:0]    hold_code, rd_code, op_code_q;
   logic [DW-1:0] hold_data, op_data_q;
   logic          new_req, start, outstanding;
   logic          push_req, push, pop, full, empty;
   logic          rd_cplt, done_set, tmo_hit;
   logic [FW-1:0] push_word, head;

   toaplan2_gcu_fifo #(.W(FW), .AW(FIFO_AW)) u_fifo (
      .clk   (CLK96),
      .rst   (RESET96),
      .push  (push),
      .pop   (pop),
      .din   (push_word),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Request capture, FIFO handshake and completion terms
   always_comb begin
      dec         = decode_op(cpu_rw, cpu_addr);
      new_req     = cpu_cs & ~cs_d;
      outstanding = wr_hold | read_pend;
      // a new edge arriving while an aborted request is still in flight waits
      start       = cpu_cs & (new_req | start_wait) & ~outstanding;
      push_req    = wr_hold | (start & ~cpu_rw & dec.hit);
      push_word   = wr_hold ? {hold_code, hold_data} : {dec.code, cpu_din};
      pop         = (state == IDLE) & ~empty;
      push        = push_req & (~full | pop);
      rd_cplt     = cur_is_read & (state == REQ) & (gcu.gcu_ack | tmo_hit);
      // completions of aborted cycles must not signal the next bus cycle
      done_set    = (start & ~dec.hit) | (push & ~(wr_hold & orphan)) |
                    (rd_cplt & ~orphan);
   end

   assign cpu_busy = cpu_cs & ~done & ~RESET96;

   // CPU-side request tracking and read data return
   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         cs_d       <= 1'b0;
         done       <= 1'b0;
         start_wait <= 1'b0;
         orphan     <= 1'b0;
         wr_hold    <= 1'b0;
         hold_code  <= '0;
         hold_data  <= '0;
         read_pend  <= 1'b0;
         rd_code    <= '0;
         cpu_dout   <= '0;
      end else begin
         cs_d       <= cpu_cs;
         done       <= cpu_cs & (done | done_set);
         start_wait <= cpu_cs & ~start & (start_wait | new_req);
         if ((wr_hold & push) | rd_cplt)
            orphan <= 1'b0;
         else if (outstanding & ~cpu_cs)
            orphan <= 1'b1;
         wr_hold <= push_req & ~push;
         if (push_req & ~push & ~wr_hold) begin
            hold_code <= dec.code;
            hold_data <= cpu_din;
         end
         if (start & cpu_rw & dec.hit) begin
            read_pend <= 1'b1;
            rd_code   <= dec.code;
         end else if (rd_cplt) begin
            read_pend <= 1'b0;
         end
         if (start & cpu_rw & ~dec.hit)
            cpu_dout <= '0;
         else if (rd_cplt)
            cpu_dout <= gcu.gcu_ack ? gcu.gcu_dout : '1;
      end
   end

   // Dispatcher state register
   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) state <= IDLE;
      else         state <= state_nxt;
   end

   // Dispatcher next state: FIFO head wins over a pending read
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (~empty | read_pend) state_nxt = REQ;
         REQ:     if (gcu.gcu_ack) state_nxt = REL;
                  else if (tmo_hit) state_nxt = IDLE;
         REL:     if (~gcu.gcu_ack | tmo_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operation latch on issue from IDLE
   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         op_code_q   <= '0;
         op_data_q   <= '0;
         cur_is_read <= 1'b0;
      end else if (state == IDLE) begin
         if (~empty) begin
            op_code_q   <= head[FW-1:DW];
            op_data_q   <= head[DW-1:0];
            cur_is_read <= 1'b0;
         end else if (read_pend) begin
            op_code_q   <= rd_code;
            op_data_q   <= '0;
            cur_is_read <= 1'b1;
         end
      end
   end

   // Dispatcher outputs: request is exactly the REQ state
   always_comb begin
      gcu.op_valid = (state == REQ);
      gcu.op_code  = op_code_q;
      gcu.op_data  = op_data_q;
   end

`ifdef TOAPLAN2_GCU_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = (state != IDLE) & (&tmo_cnt);

   // Handshake watchdog over REQ/REL with sticky timeout flag
   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         tmo_cnt  <= '0;
         tmo_flag <= 1'b0;
      end else begin
         tmo_cnt <= (state == IDLE) ? '0 : tmo_cnt + 1'b1;
         if (tmo_hit & ~((state == REQ) & gcu.gcu_ack))
            tmo_flag <= 1'b1;
      end
   end
`else
   assign tmo_hit  = 1'b0;
   assign tmo_flag = 1'b0;
`endif

endmodule

// File: tb/tb_toaplan2_gcu_seq.sv
// Directed bench for the Toaplan2 GCU sequencer. A GCU responder model
// acknowledges requests and checks them against a queue of expected
// operations pushed when the CPU stimulus is driven.
module tb_toaplan2_gcu_seq;

   typedef struct {
      logic [2:0]  code;
      logic [15:0] data;
      bit          is_rd;
   } exp_op_t;

   logic        CLK96;
   logic        RESET96;
   logic        cpu_cs;
   logic        cpu_rw;
   logic [2:0]  cpu_addr;
   logic [15:0] cpu_din;
   logic        cpu_busy;
   logic [15:0] cpu_dout;
   logic        tmo_flag;

   toaplan2_gcu_seq_if #(.DW(16)) gcu_if ();

   toaplan2_gcu_seq dut (
      .CLK96    (CLK96),
      .RESET96  (RESET96),
      .cpu_cs   (cpu_cs),
      .cpu_rw   (cpu_rw),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_busy (cpu_busy),
      .cpu_dout (cpu_dout),
      .tmo_flag (tmo_flag),
      .gcu      (gcu_if)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          ops_seen = 0;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   bit          ack_hold = 0;
   logic [15:0] rd_data = 16'h0000;
   exp_op_t     exp_q[$];

   initial CLK96 = 1'b0;
   always #5 CLK96 = ~CLK96;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_op(input logic [2:0] code, input logic [15:0] data, input bit is_rd);
      exp_op_t e;
      e.code  = code;
      e.data  = data;
      e.is_rd = is_rd;
      exp_q.push_back(e);
   endtask

   // GCU responder: acknowledges after ack_delay cycles, checks each op in order
   always @(posedge CLK96) begin
      exp_op_t e;
      #1;
      if (RESET96) begin
         gcu_if.gcu_ack = 1'b0;
         wait_cnt = 0;
      end else if (!gcu_if.gcu_ack) begin
         if (gcu_if.op_valid && !ack_hold) begin
            if (wait_cnt >= ack_delay) begin
               ops_seen++;
               check("op_expected", (exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("op_code", gcu_if.op_code, e.code);
                  if (!e.is_rd) check("op_data", gcu_if.op_data, e.data);
               end
               gcu_if.gcu_dout = rd_data;
               gcu_if.gcu_ack  = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end else if (!gcu_if.op_valid) begin
         gcu_if.gcu_ack = 1'b0;
      end
   end

   // One CPU bus cycle; bcyc returns the number of sampled busy cycles
   task automatic access(input bit rw, input logic [2:0] a, input logic [15:0] d, output int bcyc);
      @(posedge CLK96); #1;
      cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_din = d;
      bcyc = 0;
      while (bcyc < 3000) begin
         @(negedge CLK96);
         if (!cpu_busy) break;
         bcyc++;
      end
      @(posedge CLK96); #1;
      cpu_cs = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (n < 500) begin
         @(negedge CLK96);
         if (exp_q.size() == 0 && !gcu_if.op_valid && !gcu_if.gcu_ack) break;
         n++;
      end
      check(tag, (n < 500), 1);
   endtask

   initial begin
      int b;
      int seen0;
      logic [2:0]  waddr [6];
      logic [2:0]  wcode [6];
      waddr = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd2};
      wcode = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd5, 3'd1};

      RESET96 = 1'b1; cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd4; cpu_din = 16'h0;
      gcu_if.gcu_ack = 1'b0; gcu_if.gcu_dout = 16'h0;
      repeat (3) @(negedge CLK96);
      check("rst_op_valid", gcu_if.op_valid, 0);
      check("rst_busy", cpu_busy, 0);
      check("rst_dout", cpu_dout, 0);
      check("rst_tmo", tmo_flag, 0);
      cpu_cs = 1'b0;
      @(posedge CLK96); #1; RESET96 = 1'b0;
      repeat (2) @(posedge CLK96);

      // single SELECT_REG write, ack two cycles after request
      ack_delay = 2;
      expect_op(3'd4, 16'h0003, 0);
      access(0, 3'd4, 16'h0003, b);
      check("wr_busy_1cyc", b, 1);
      drain("t1_drain");

      // write pointer then read: program order and read data return
      ack_delay = 0;
      rd_data = 16'hBEEF;
      expect_op(3'd0, 16'h1234, 0);
      expect_op(3'd2, 16'h0000, 1);
      access(0, 3'd0, 16'h1234, b);
      check("ptr_busy_1cyc", b, 1);
      access(1, 3'd2, 16'h0000, b);
      check("rd_busy_gt1", (b > 1 && b < 3000), 1);
      check("rd_dout", cpu_dout, 16'hBEEF);
      drain("t3_drain");

      // unmapped read and write: no op, zero data, single busy cycle
      seen0 = ops_seen;
      access(1, 3'd5, 16'h0000, b);
      check("unm_rd_busy", b, 1);
      check("unm_rd_dout", cpu_dout, 0);
      access(0, 3'd1, 16'hAAAA, b);
      check("unm_wr_busy", b, 1);
      repeat (10) @(negedge CLK96);
      check("unm_no_op", ops_seen, seen0);

      // six writes with ack held off: FIFO fills, sixth stalls
      ack_hold = 1;
      for (int i = 0; i < 6; i++) expect_op(wcode[i], 16'h0100 + 16'(i), 0);
      for (int i = 0; i < 5; i++) begin
         access(0, waddr[i], 16'h0100 + 16'(i), b);
         check("q_busy_1cyc", b, 1);
      end
      @(posedge CLK96); #1;
      cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = waddr[5]; cpu_din = 16'h0105;
      repeat (6) @(negedge CLK96);
      check("full_busy_held", cpu_busy, 1);
      ack_hold = 0;
      b = 0;
      while (b < 200) begin
         @(negedge CLK96);
         if (!cpu_busy) break;
         b++;
      end
      check("full_busy_fell", (b < 200), 1);
      @(posedge CLK96); #1; cpu_cs = 1'b0;
      drain("t2_drain");

      // reset in REQ with three queued writes
      ack_hold = 1;
      for (int i = 0; i < 4; i++) access(0, 3'd6, 16'h0200 + 16'(i), b);
      @(posedge CLK96); #1;
      cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd4; cpu_din = 16'h0300;
      #1;
      check("pre_rst_busy", cpu_busy, 1);
      check("pre_rst_valid", gcu_if.op_valid, 1);
      #1; RESET96 = 1'b1;
      #1;
      check("async_rst_valid", gcu_if.op_valid, 0);
      check("async_rst_busy", cpu_busy, 0);
      @(posedge CLK96); #1; cpu_cs = 1'b0;
      repeat (2) @(posedge CLK96);
      #1; RESET96 = 1'b0; ack_hold = 0;
      seen0 = ops_seen;
      repeat (20) @(negedge CLK96);
      check("post_rst_no_op", ops_seen, seen0);
      expect_op(3'd4, 16'h0055, 0);
      access(0, 3'd4, 16'h0055, b);
      check("post_rst_busy", b, 1);
      drain("t5_drain");

`ifdef TOAPLAN2_GCU_TIMEOUT_EN
      // read with GCU never acknowledging
      ack_hold = 1;
      access(1, 3'd3, 16'h0000, b);
      check("tmo_latency", (b >= 1023 && b <= 1030), 1);
      check("tmo_dout", cpu_dout, 16'hFFFF);
      check("tmo_flag_set", tmo_flag, 1);
      repeat (10) @(negedge CLK96);
      check("tmo_flag_sticky", tmo_flag, 1);
      check("tmo_valid_low", gcu_if.op_valid, 0);
      ack_hold = 0;
`else
      check("tmo_flag_tied", tmo_flag, 0);
`endif

      check("queue_empty_end", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/toaplan2_gcu_seq.md
Name: toaplan2_gcu_seq

Overview:
Sequencer between the 68k bus decode and the GP9001 command port.
- Turns CPU accesses in the 0x140000-0x14000D window into single GCU operations.
- Queues writes in a small posted-write FIFO; reads block until all queued writes have drained and the GCU has returned data.
- Runs a 4-phase req/ack handshake to the GCU and drives the busy term used by the 68k DTACK generator.

Parameters:
- FIFO_AW, 2: log2 of posted-write FIFO depth (default 4 entries).
- DW, 16: data width of CPU and GCU data.
- TMO_W, 10: timeout counter width; used only with the optional feature.

Ports:
- CLK96  in  1  system clock.
- RESET96  in  1  asynchronous, active-high reset.
- cpu_cs  in  1  GCU window select, held for the whole bus cycle.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  3  A[3:1] of the access.
- cpu_din  in  DW  CPU write data.
- cpu_busy  out  1  hold off DTACK while high.
- cpu_dout  out  DW  read data, valid once cpu_busy falls.
- op_valid  out  1  GCU request.
- op_code  out  3  operation code.
- op_data  out  DW  write payload.
- gcu_ack  in  1  GCU acknowledge.
- gcu_dout  in  DW  GCU read data, valid while gcu_ack is high.
- tmo_flag  out  1  sticky timeout indicator; constant 0 without the optional feature.

Behaviour:
- Reset: RESET96 is asynchronous, active-high, on clock CLK96. During reset, all state is cleared and all outputs are 0. Reset mid-operation abandons any in-flight op and empties the FIFO.
- Op codes by byte address, write: 0x0 SET_RAM_PTR=0, 0x4/0x6 WRITE_RAM=1, 0x8 SELECT_REG=4, 0xC WRITE_REG=5.
- Op codes by byte address, read: 0x4 READ_RAM_H=2, 0x6 READ_RAM_L=3.
- Unmapped accesses: any other address/direction completes with no op; reads of these return 0.
- Request capture: one request per cpu_cs rising edge, from a registered edge detect.
- Done flag: registered `done` sets when the current request completes and clears when cpu_cs falls.
- cpu_busy = cpu_cs & ~done (combinational), so busy is high for at least 1 cycle per access.
- Write path: the {code, data} pair is pushed into the FIFO on the cycle after the cs edge if not full, and done sets on that same edge.
- Write into a full FIFO: the push is held and busy stays high until a slot frees.
- Simultaneous push and pop on a full FIFO: allowed and accepted in the same cycle.
- Read path: sets read_pend. The read op is issued only when the FIFO is empty and the dispatcher is IDLE, which preserves program order.
- Read completion: gcu_dout is latched into cpu_dout on the ack cycle, and done sets on the next edge. cpu_dout holds until the next read completes.
- Dispatcher FSM, IDLE: if FIFO non-empty, pop the head into op_code/op_data, raise op_valid, go to REQ. Otherwise, if read_pend, issue the read op and go to REQ. The FIFO head has priority over a pending read.
- Dispatcher FSM, REQ: hold op_valid, op_code and op_data stable. When gcu_ack is high, drop op_valid on the next edge, latch read data if the op is a read, and go to REL.
- Dispatcher FSM, REL: wait for gcu_ack low, then go to IDLE. Throughput is at most one op per 3 cycles with zero-latency ack.
- gcu_ack high while in IDLE is ignored.
- FIFO counters: pointer wrap-around is modulo 2^FIFO_AW; full/empty are derived from a FIFO_AW+1 bit count.
- cpu_cs dropping while busy (aborted cycle): the request is still completed and the result discarded.

Optional Feature:
- Macro: TOAPLAN2_GCU_TIMEOUT_EN.
- With the macro: a TMO_W-bit counter runs in REQ and REL. At all-ones it forces IDLE and drops op_valid.
  - A timed-out read returns 16'hFFFF and completes.
  - tmo_flag sets and stays set until reset.
- Without the macro: no counter; the sequencer waits forever and tmo_flag is tied to 0.

Decomposition:
- Package toaplan2_gcu_pkg:
  - op code constants, 3-bit localparams OP_SET_PTR, OP_WR_RAM, OP_RD_H, OP_RD_L, OP_SEL_REG, OP_WR_REG;
  - FSM state encoding IDLE/REQ/REL;
  - address-to-op decode function.
- One sub-module, toaplan2_gcu_fifo: synchronous FIFO of width 3+DW, FIFO_AW address bits, with push/pop/full/empty outputs.

Test Plan:
- Single write to 0x8 with data 0x0003, ack 2 cycles later: op_code=4 and op_data=0x0003 held until ack; cpu_busy high for exactly 1 cycle.
- Six back-to-back writes with ack held off: the first pops, four queue, and busy stays high on the sixth until ack frees a slot. GCU sees all six in order.
- Write 0x0 with 0x1234 then immediately read 0x4: SET_RAM_PTR is issued before READ_RAM_H. gcu_dout=0xBEEF appears on cpu_dout when busy falls.
- Read of address 0xA: no op_valid, cpu_dout=0, busy 1 cycle.
- RESET96 asserted in REQ with 3 queued writes: op_valid, cpu_busy and FIFO count are 0 immediately and asynchronously; after release, no stale op is issued.
- With TOAPLAN2_GCU_TIMEOUT_EN and gcu_ack tied low on a read of 0x6: after 1023 cycles cpu_dout=0xFFFF, busy falls, tmo_flag=1 and stays 1.
